// File: rtl/fp32_to_int_cvt.sv
// fp32_to_int_cvt: multi-cycle IEEE-754 single precision to signed integer
// converter. The mantissa is aligned by an iterative shifter that moves one
// bit per cycle. Out-of-range inputs and NaN saturate and raise out_invalid.
// Optional macro FP2INT_ROUND_NEAREST_EN selects round-to-nearest-even;
// when undefined the converter truncates toward zero.
module fp32_to_int_cvt #(
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_invalid,
  output logic                 out_inexact
);

  // The working register must hold the full 24-bit significand before any
  // right shift, even for narrow result widths.
  localparam int MAG_W = (OUT_WIDTH + 1 > 24) ? OUT_WIDTH + 1 : 24;
  // Smallest biased exponent whose magnitude cannot fit (k >= OUT_WIDTH-1).
  localparam logic [8:0] E_SAT = 9'(126 + OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t           state_reg, state_next;
  logic             sign_reg;
  logic [7:0]       exp_reg;
  logic             frac_nz_reg;
  logic [MAG_W-1:0] work_reg;
  logic [7:0]       cnt_reg;
  logic             shl_reg;
  logic             guard_reg;
  logic             sticky_reg;
  logic [OUT_WIDTH-1:0] data_reg;
  logic             invalid_reg;
  logic             inexact_reg;

  // Input-side decode used only on the accept edge
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic        in_special;
  logic        accept;

  assign in_exp     = in_data[30:23];
  assign in_frac    = in_data[22:0];
  assign in_special = (in_exp == 8'hFF) || (in_exp < 8'd126) ||
                      ({1'b0, in_exp} >= E_SAT);
  assign accept     = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)       state_next = SHIFT;
      SHIFT:   if (cnt_reg == 8'd0) state_next = ROUND;
      ROUND:                        state_next = DONE;
      DONE:    if (out_ready)      state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // Rounding, range check and sign application for the ROUND state
  logic [OUT_WIDTH-1:0] mag;
  logic                 hi_nz;
  logic                 mag_ovf;
  logic [OUT_WIDTH-1:0] res_data;
  logic                 res_inv;
  logic                 res_inx;

  always_comb begin
`ifdef FP2INT_ROUND_NEAREST_EN
    mag = work_reg[OUT_WIDTH-1:0] +
          OUT_WIDTH'(guard_reg && (sticky_reg || work_reg[0]));
`else
    mag = work_reg[OUT_WIDTH-1:0];
`endif
    hi_nz   = |work_reg[MAG_W-1:OUT_WIDTH];
    // Only the exact minimum negative value may use the top bit.
    mag_ovf = hi_nz || (mag[OUT_WIDTH-1] && !(sign_reg && (mag == MIN_NEG)));
    res_data = '0;
    res_inv  = 1'b0;
    res_inx  = 1'b0;
    if (exp_reg == 8'hFF) begin
      res_inv  = 1'b1;
      res_data = (sign_reg && !frac_nz_reg) ? MIN_NEG : MAX_POS;
    end else if (exp_reg == 8'd0) begin
      res_inx = frac_nz_reg;
    end else if (exp_reg < 8'd126) begin
      res_inx = 1'b1;
    end else if ({1'b0, exp_reg} >= E_SAT) begin
      res_data = sign_reg ? MIN_NEG : MAX_POS;
      res_inv  = !(sign_reg && ({1'b0, exp_reg} == E_SAT) && !frac_nz_reg);
    end else begin
      res_inx = guard_reg || sticky_reg;
      if (mag_ovf) begin
        res_data = sign_reg ? MIN_NEG : MAX_POS;
        res_inv  = 1'b1;
      end else begin
        res_data = sign_reg ? -mag : mag;
      end
    end
  end

  // Datapath: operand capture, iterative shifter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg    <= 1'b0;
      exp_reg     <= 8'd0;
      frac_nz_reg <= 1'b0;
      work_reg    <= '0;
      cnt_reg     <= 8'd0;
      shl_reg     <= 1'b0;
      guard_reg   <= 1'b0;
      sticky_reg  <= 1'b0;
      data_reg    <= '0;
      invalid_reg <= 1'b0;
      inexact_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          sign_reg    <= in_data[31];
          exp_reg     <= in_exp;
          frac_nz_reg <= |in_frac;
          work_reg    <= MAG_W'({(in_exp != 8'd0), in_frac});
          guard_reg   <= 1'b0;
          sticky_reg  <= 1'b0;
          if (in_special) begin
            cnt_reg <= 8'd0;
            shl_reg <= 1'b0;
          end else if (in_exp >= 8'd150) begin
            cnt_reg <= in_exp - 8'd150;
            shl_reg <= 1'b1;
          end else begin
            cnt_reg <= 8'd150 - in_exp;
            shl_reg <= 1'b0;
          end
        end
        SHIFT: if (cnt_reg != 8'd0) begin
          cnt_reg <= cnt_reg - 8'd1;
          if (shl_reg) begin
            work_reg <= work_reg << 1;
          end else begin
            // The most recent bit out is the guard; older ones fold into sticky.
            work_reg   <= work_reg >> 1;
            guard_reg  <= work_reg[0];
            sticky_reg <= sticky_reg || guard_reg;
          end
        end
        ROUND: begin
          data_reg    <= res_data;
          invalid_reg <= res_inv;
          inexact_reg <= res_inx;
        end
        default: ;
      endcase
    end
  end

  assign out_data    = data_reg;
  assign out_invalid = invalid_reg;
  assign out_inexact = inexact_reg;

endmodule

// File: tb/tb_fp32_to_int_cvt.sv
// Testbench for fp32_to_int_cvt (OUT_WIDTH=32): directed vectors with
// hand-computed results, plus an arithmetic reference model checked on every
// cycle that out_valid is high.
module tb_fp32_to_int_cvt;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_inexact;

  fp32_to_int_cvt #(.OUT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
    logic        inx;
    int          lat;
  } res_t;

  int   n_cmp  = 0;
  int   n_miss = 0;
  bit   pending = 1'b0;
  res_t cur_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact value M * 2^(E-150) in 64-bit arithmetic, then round,
  // sign and clamp to the 32-bit signed range.
  function automatic res_t model(input logic [31:0] v);
    res_t   r;
    bit     s;
    int     e, sh;
    longint m, mag, rem, half, val;
    s = v[31];
    e = int'(v[30:23]);
    m = longint'({(e != 0), v[22:0]});
    r.data = 32'd0; r.inv = 1'b0; r.inx = 1'b0;
    r.lat  = (e == 255 || e < 126 || e >= 158) ? 2 : ((e >= 150) ? e - 150 : 150 - e) + 2;
    if (e == 255) begin
      r.inv  = 1'b1;
      r.data = (v[22:0] != 0 || !s) ? 32'h7FFFFFFF : 32'h80000000;
    end else if (e == 0) begin
      r.inx = (v[22:0] != 0);
    end else if (e < 126) begin
      r.inx = 1'b1;
    end else if (e >= 190) begin
      r.inv  = 1'b1;
      r.data = s ? 32'h80000000 : 32'h7FFFFFFF;
    end else begin
      if (e >= 150) begin
        mag = m << (e - 150); rem = 0; half = 0;
      end else begin
        sh   = 150 - e;
        mag  = m >> sh;
        rem  = m - (mag << sh);
        half = longint'(1) << (sh - 1);
      end
      r.inx = (rem != 0);
`ifdef FP2INT_ROUND_NEAREST_EN
      if (rem > half || (rem == half && rem != 0 && mag[0])) mag = mag + 1;
`endif
      val = s ? -mag : mag;
      if (val > 64'sd2147483647) begin
        r.inv = 1'b1; r.data = 32'h7FFFFFFF;
      end else if (val < -64'sd2147483648) begin
        r.inv = 1'b1; r.data = 32'h80000000;
      end else begin
        r.data = val[31:0];
      end
    end
    return r;
  endfunction

  // Compare process: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("no_stale_valid", 64'(pending), 64'd1);
      if (pending) begin
        check("model_data", 64'(out_data), 64'(cur_exp.data));
        check("model_invalid", 64'(out_invalid), 64'(cur_exp.inv));
        check("model_inexact", 64'(out_inexact), 64'(cur_exp.inx));
        check("in_ready_low", 64'(in_ready), 64'd0);
      end
    end
  end

  task automatic run(input logic [31:0] v, input logic [31:0] ed, input logic ei,
                     input logic ex, input int el, input int hold);
    res_t        m;
    int          lat;
    logic [31:0] d0;
    logic        i0, x0;
    m = model(v);
    check("model_pin_data", 64'(m.data), 64'(ed));
    check("model_pin_inv", 64'(m.inv), 64'(ei));
    check("model_pin_inx", 64'(m.inx), 64'(ex));
    check("model_pin_lat", 64'(m.lat), 64'(el));
    check("idle_before", 64'(in_ready), 64'd1);
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~v;
    cur_exp  = m;
    pending  = 1'b1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("result_timeout", 64'(out_valid), 64'd1);
    if (!out_valid) begin
      pending = 1'b0;
      return;
    end
    check("latency", 64'(lat), 64'(el));
    check("lit_data", 64'(out_data), 64'(ed));
    check("lit_invalid", 64'(out_invalid), 64'(ei));
    check("lit_inexact", 64'(out_inexact), 64'(ex));
    d0 = out_data; i0 = out_invalid; x0 = out_inexact;
    repeat (hold) begin @(posedge clk); #1; end
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_data", 64'({d0, i0, x0}), 64'({out_data, out_invalid, out_inexact}));
    // Offer a new input during the output handshake; it must not be taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h3F800000;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    pending   = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
    check("ready_back", 64'(in_ready), 64'd1);
    $display("vec %h -> %h inv=%b inx=%b lat=%0d", v, d0, i0, x0, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_flags", 64'({out_invalid, out_inexact}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // value, data, invalid, inexact, latency, hold cycles
    run(32'hC2F60000, 32'hFFFFFF85, 1'b0, 1'b0, 19, 5);
`ifdef FP2INT_ROUND_NEAREST_EN
    run(32'h3FC00000, 32'h00000002, 1'b0, 1'b1, 25, 0);
    run(32'h40200000, 32'h00000002, 1'b0, 1'b1, 24, 1);
    run(32'hBF7FFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 26, 0);
    run(32'h3FFFFFFF, 32'h00000002, 1'b0, 1'b1, 25, 0);
    run(32'h40600000, 32'h00000004, 1'b0, 1'b1, 24, 0);
`else
    run(32'h3FC00000, 32'h00000001, 1'b0, 1'b1, 25, 0);
    run(32'h40200000, 32'h00000002, 1'b0, 1'b1, 24, 1);
    run(32'hBF7FFFFF, 32'h00000000, 1'b0, 1'b1, 26, 0);
    run(32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b1, 25, 0);
    run(32'h40600000, 32'h00000003, 1'b0, 1'b1, 24, 0);
`endif
    run(32'h3FA00000, 32'h00000001, 1'b0, 1'b1, 25, 0);
    run(32'h3F000000, 32'h00000000, 1'b0, 1'b1, 26, 0);
    run(32'h3E800000, 32'h00000000, 1'b0, 1'b1, 2, 0);
    run(32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2, 2);
    run(32'hCF000000, 32'h80000000, 1'b0, 1'b0, 2, 0);
    run(32'hFF800000, 32'h80000000, 1'b1, 1'b0, 2, 0);
    run(32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 2, 0);
    run(32'h00000001, 32'h00000000, 1'b0, 1'b1, 2, 0);
    run(32'h80000000, 32'h00000000, 1'b0, 1'b0, 2, 0);
    run(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9, 0);
    run(32'hCEFFFFFF, 32'h80000080, 1'b0, 1'b0, 9, 0);
    run(32'h4B000000, 32'h00800000, 1'b0, 1'b0, 2, 0);
    run(32'h40400000, 32'h00000003, 1'b0, 1'b0, 24, 0);

    // Reset in the middle of SHIFT aborts without producing a result
    in_data = 32'h3FC00000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_output", 64'(out_valid), 64'd0);
    $display("reset during SHIFT: in_ready=%b out_valid=%b", in_ready, out_valid);
    run(32'h41200000, 32'h0000000A, 1'b0, 1'b0, 22, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/fp32_to_int_cvt.md
Name: fp32_to_int_cvt

Overview:
Multi-cycle converter from IEEE-754 single precision to a signed two's-complement integer. It is the decode-side counterpart of the FP32 add/sub datapath: it unpacks the packed {sign, exponent, mantissa} word into a fixed-point integer. Its mantissa shifter is iterative and moves one bit per cycle. It sits between FP result producers and integer consumers, with valid/ready handshakes on both sides. Out-of-range inputs and NaN saturate and raise flags.

Parameters:
OUT_WIDTH, 32, width of the signed integer result; legal range 8..32.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data valid
in_ready  output  1  converter idle, can accept
in_data  input  32  FP32 operand {sign, exp[7:0], frac[22:0]}
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
out_data  output  OUT_WIDTH  signed integer result
out_invalid  output  1  NaN, infinity, or out-of-range input (saturated)
out_inexact  output  1  discarded fraction bits were non-zero

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out_data=0; out_invalid=0; out_inexact=0. Reset in any state aborts the operation without producing output.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready, latch sign, E, and M={E!=0, frac}, then go to SHIFT.
  - SHIFT: in_ready=0. Shift the working magnitude by one bit per cycle while cnt!=0, decrementing cnt. Go to ROUND when cnt==0.
  - ROUND: apply rounding, range check, and sign. Load outputs. Go to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready go to IDLE; in_ready=1 on the following cycle. A new input is never accepted in the same cycle as output handshake.
- Shift count, with k = E-127:
  - E>=150: left shift, cnt=E-150.
  - 126<=E<150: right shift, cnt=150-E. Bits shifted out of LSB: the first becomes guard, all later ones OR into sticky.
  - Special cases set cnt=0 and pass through SHIFT in one cycle: E==0xFF, E<126, or k>=OUT_WIDTH-1.
- Latency: out_valid rises cnt+2 cycles after the accept edge (special cases: 2 cycles).
- Working magnitude register: OUT_WIDTH+1 bits. A left shift never exceeds it, because overflow is classified before SHIFT.
- Special cases:
  - NaN (E=0xFF, frac!=0): out_data = max positive (2^(OUT_WIDTH-1)-1); invalid=1.
  - +inf, or positive with k>=OUT_WIDTH-1: max positive; invalid=1.
  - -inf, or negative with k>=OUT_WIDTH-1: min negative (-2^(OUT_WIDTH-1)). invalid=1, except for the exact value -2^(OUT_WIDTH-1) (k==OUT_WIDTH-1, frac==0), which gives invalid=0.
  - E==0 (zero or denormal): out_data=0. inexact = |frac.
  - E<126 (|x|<0.5): out_data=0. inexact=1. Negative input never yields a negative zero encoding.
- Default rounding: truncate toward zero. magnitude = shifted integer part; inexact = guard|sticky.
- Sign: result = sign ? -magnitude : magnitude, computed in OUT_WIDTH bits.
- Output registers hold stable while out_valid=1 and out_ready=0.
- in_data is sampled only on the accept edge; later changes are ignored.

Optional Feature:
Macro FP2INT_ROUND_NEAREST_EN.
- Defined: round to nearest, ties to even, on the magnitude: increment if guard && (sticky || lsb).
  - If the increment reaches 2^(OUT_WIDTH-1) for a positive input, saturate to max positive with invalid=1. For a negative input it is legal as min negative.
  - Inputs with E<126 still give 0 with inexact=1.
  - Latency is unchanged.
- Undefined: truncation only; no rounding adder is instantiated.

Test Plan:
- 0xC2F60000 (-123.0) -> out_data=0xFFFFFF85, invalid=0, inexact=0, out_valid 19 cycles after accept (cnt=17).
- 0x3FC00000 (1.5) -> 1, inexact=1, latency 25. 0x40200000 (2.5) -> 2, inexact=1. With FP2INT_ROUND_NEAREST_EN: 1.5 -> 2, 2.5 -> 2 (tie to even).
- 0x4F000000 (2^31) -> 0x7FFFFFFF, invalid=1. 0xCF000000 -> 0x80000000, invalid=0. 0xFF800000 (-inf) -> 0x80000000, invalid=1. All with latency 2.
- 0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid=1. 0x00000001 -> 0, inexact=1. 0x80000000 (-0) -> 0, both flags 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data and flags stable, in_ready=0 throughout. Assert out_ready -> out_valid drops next cycle, in_ready=1.
- Assert rst in mid-SHIFT while converting 0x3FC00000 -> next cycle IDLE, in_ready=1, out_valid=0, no stale output. A following 0x41200000 (10.0) -> 0x0000000A.
